scm_bist_ctrl: RTL and testbench

// - Synthesizable built-in self-test initiator for the standard-cell memory (SCM) macro.
// - Drives the memory's write port (WE/WADDR/DIN) and read port (RE/RADDR), then checks the returned DOUT.
// - Write pass: sequential writes of every row with LFSR data.
// - Read pass: sequential read-back, compared against a regenerated LFSR stream.
// - Sits beside the SCM instance; a top-level controller or scan sequencer starts it and collects the verdict.

---
 rtl/scm_bist_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_scm_bist_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/scm_bist_ctrl.sv
// Built-in self-test initiator for the standard-cell memory: LFSR write pass, read-back pass, verdict.
// Optional build macro SCM_BIST_INV_PASS_EN adds a second pass with bitwise-inverted data.
module scm_bist_ctrl #(
  parameter int ADDR_WIDTH   = 6,
  parameter int DATA_WIDTH   = 64,
  parameter int READ_LATENCY = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [31:0]           i_seed,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_pass,
  output logic [15:0]           o_err_count,
  output logic [ADDR_WIDTH-1:0] o_first_err_addr,
  output logic                  o_we,
  output logic [ADDR_WIDTH-1:0] o_waddr,
  output logic [DATA_WIDTH-1:0] o_din,
  output logic                  o_re,
  output logic [ADDR_WIDTH-1:0] o_raddr,
  output logic                  o_se,
  input  logic [DATA_WIDTH-1:0] i_dout
);

  localparam int NUM_ROWS   = 2 ** ADDR_WIDTH;
  localparam int PIPE_DEPTH = READ_LATENCY + 1;
  localparam int CNT_W      = $clog2(PIPE_DEPTH + 1);

  localparam logic [ADDR_WIDTH-1:0] LAST_ROW   = ADDR_WIDTH'(NUM_ROWS - 1);
  localparam logic [CNT_W-1:0]      DRAIN_LAST = CNT_W'(PIPE_DEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_GAP   = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  // Fibonacci LFSR, x^32 + x^22 + x^2 + x + 1, shifting towards the MSB
  function automatic logic [31:0] lfsrStep(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] expandWord(input logic [31:0] s);
    logic [DATA_WIDTH-1:0] w;
    w = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      w[i] = s[i % 32];
    end
    return w;
  endfunction

  logic [2:0]            r_state;
  logic [31:0]           r_lfsr;
  logic [31:0]           r_seed;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [CNT_W-1:0]      r_drainCnt;
  logic                  r_wrDone;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_pass;
  logic [15:0]           r_errCount;
  logic [ADDR_WIDTH-1:0] r_firstErrAddr;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [DATA_WIDTH-1:0] r_din;
  logic                  r_re;
  logic [ADDR_WIDTH-1:0] r_raddr;

  logic                  r_pipeVld  [PIPE_DEPTH];
  logic [DATA_WIDTH-1:0] r_pipeExp  [PIPE_DEPTH];
  logic [ADDR_WIDTH-1:0] r_pipeAddr [PIPE_DEPTH];

  logic                  w_startOk;
  logic [31:0]           w_effSeed;
  logic [DATA_WIDTH-1:0] w_word;
  logic                  w_mismatch;
  logic [ADDR_WIDTH-1:0] w_cmpAddr;

  assign w_startOk = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_effSeed = (i_seed == 32'd0) ? 32'h1 : i_seed;

`ifdef SCM_BIST_INV_PASS_EN
  logic r_inv;
  assign w_word = expandWord(r_lfsr) ^ {DATA_WIDTH{r_inv}};
`else
  assign w_word = expandWord(r_lfsr);
`endif

  assign w_mismatch = r_pipeVld[READ_LATENCY] && (i_dout != r_pipeExp[READ_LATENCY]);
  assign w_cmpAddr  = r_pipeAddr[READ_LATENCY];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_lfsr     <= 32'd0;
      r_seed     <= 32'd0;
      r_addr     <= '0;
      r_drainCnt <= '0;
      r_wrDone   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_din      <= '0;
      r_re       <= 1'b0;
      r_raddr    <= '0;
`ifdef SCM_BIST_INV_PASS_EN
      r_inv      <= 1'b0;
`endif
    end else if (w_startOk) begin
      r_state  <= S_WRITE;
      r_lfsr   <= w_effSeed;
      r_seed   <= w_effSeed;
      r_addr   <= '0;
      r_wrDone <= 1'b0;
      r_busy   <= 1'b1;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
`ifdef SCM_BIST_INV_PASS_EN
      r_inv    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_WRITE: begin
          r_we    <= 1'b1;
          r_waddr <= r_addr;
          r_din   <= w_word;
          r_lfsr  <= lfsrStep(r_lfsr);
          if (r_addr == LAST_ROW) begin
            r_addr   <= '0;
            r_wrDone <= 1'b1;
            r_state  <= S_GAP;
          end else begin
            r_addr <= r_addr + ADDR_WIDTH'(1);
          end
        end
        // GAP separates the passes and rewinds the LFSR so reads regenerate the written stream
        S_GAP: begin
          r_we   <= 1'b0;
          r_re   <= 1'b0;
          r_lfsr <= r_seed;
          r_addr <= '0;
          if (r_wrDone) begin
            r_wrDone <= 1'b0;
            r_state  <= S_READ;
          end else begin
            r_state <= S_WRITE;
          end
        end
        S_READ: begin
          r_re    <= 1'b1;
          r_raddr <= r_addr;
          r_lfsr  <= lfsrStep(r_lfsr);
          if (r_addr == LAST_ROW) begin
            r_addr     <= '0;
            r_drainCnt <= '0;
            r_state    <= S_DRAIN;
          end else begin
            r_addr <= r_addr + ADDR_WIDTH'(1);
          end
        end
        S_DRAIN: begin
          r_re <= 1'b0;
          if (r_drainCnt == DRAIN_LAST) begin
`ifdef SCM_BIST_INV_PASS_EN
            if (!r_inv) begin
              r_inv   <= 1'b1;
              r_state <= S_GAP;
            end else begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (r_errCount == 16'd0) && !w_mismatch;
            end
`else
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (r_errCount == 16'd0) && !w_mismatch;
`endif
          end else begin
            r_drainCnt <= r_drainCnt + CNT_W'(1);
          end
        end
        S_IDLE, S_DONE: begin
          r_we <= 1'b0;
          r_re <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Expected word and address travel alongside the read until the memory returns DOUT
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        r_pipeVld[i]  <= 1'b0;
        r_pipeExp[i]  <= '0;
        r_pipeAddr[i] <= '0;
      end
    end else begin
      r_pipeVld[0]  <= (r_state == S_READ);
      r_pipeExp[0]  <= w_word;
      r_pipeAddr[0] <= r_addr;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        r_pipeVld[i]  <= r_pipeVld[i-1];
        r_pipeExp[i]  <= r_pipeExp[i-1];
        r_pipeAddr[i] <= r_pipeAddr[i-1];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_errCount     <= 16'd0;
      r_firstErrAddr <= '0;
    end else if (w_startOk) begin
      r_errCount     <= 16'd0;
      r_firstErrAddr <= '0;
    end else if (w_mismatch) begin
      if (r_errCount != 16'hFFFF) begin
        r_errCount <= r_errCount + 16'd1;
      end
      if (r_errCount == 16'd0) begin
        r_firstErrAddr <= w_cmpAddr;
      end
    end
  end

  assign o_busy           = r_busy;
  assign o_done           = r_done;
  assign o_pass           = r_pass;
  assign o_err_count      = r_errCount;
  assign o_first_err_addr = r_firstErrAddr;
  assign o_we             = r_we;
  assign o_waddr          = r_waddr;
  assign o_din            = r_din;
  assign o_re             = r_re;
  assign o_raddr          = r_raddr;
  assign o_se             = 1'b0;

endmodule

// File: tb/tb_scm_bist_ctrl.sv
// Bench for scm_bist_ctrl: behavioural SCM model, write/read scoreboard, table of full runs plus corner sequences.
// Honours SCM_BIST_INV_PASS_EN for the expected pass count and completion edge.
module tb_scm_bist_ctrl;

  localparam int AW    = 6;
  localparam int DW    = 64;
  localparam int RL    = 1;
  localparam int NROWS = 64;
`ifdef SCM_BIST_INV_PASS_EN
  localparam int PASSES    = 2;
  localparam int DONE_EDGE = 4*NROWS + 2*RL + 7;
`else
  localparam int PASSES    = 1;
  localparam int DONE_EDGE = 2*NROWS + RL + 3;
`endif
  localparam logic [15:0] FLIP_ERRS = 16'(PASSES);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [31:0]   seed;
  logic          o_busy, o_done, o_pass, o_we, o_re, o_se;
  logic [15:0]   o_err_count;
  logic [AW-1:0] o_first_err_addr, o_waddr, o_raddr;
  logic [DW-1:0] o_din;
  logic [DW-1:0] dout;

  always #5 clk = ~clk;

  scm_bist_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_seed(seed),
    .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass), .o_err_count(o_err_count),
    .o_first_err_addr(o_first_err_addr), .o_we(o_we), .o_waddr(o_waddr), .o_din(o_din),
    .o_re(o_re), .o_raddr(o_raddr), .o_se(o_se), .i_dout(dout)
  );

  // SCM model with one-edge read latency; faultMode 1 flips bit 0 of row 5, mode 2 returns 0 for rows 10..12
  int            faultMode = 0;
  logic [DW-1:0] mem [NROWS];
  always @(posedge clk) begin
    if (o_we) mem[o_waddr] <= o_din;
    if (o_re) begin
      if (faultMode == 1 && o_raddr == 6'd5)
        dout <= mem[o_raddr] ^ 64'h1;
      else if (faultMode == 2 && o_raddr >= 6'd10 && o_raddr <= 6'd12)
        dout <= '0;
      else
        dout <= mem[o_raddr];
    end
  end

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wrExp_t;

  wrExp_t        wrQ [$];
  logic [AW-1:0] rdQ [$];
  int            nCompared = 0;
  int            nMismatched = 0;
  bit            monOn = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] modelStep(input logic [31:0] s);
    return {s[30:0], ^(s & 32'h8020_0003)};
  endfunction

  function automatic logic [DW-1:0] modelWord(input logic [31:0] s);
    logic [DW-1:0] w;
    w = '0;
    for (int i = 0; i < DW; i++) w[i] = s[i % 32];
    return w;
  endfunction

  task automatic pushExpected(input logic [31:0] sd);
    logic [31:0]   s;
    logic [DW-1:0] inv;
    wrExp_t        e;
    for (int p = 0; p < PASSES; p++) begin
      s   = (sd == 32'd0) ? 32'h1 : sd;
      inv = (p == 1) ? {DW{1'b1}} : '0;
      for (int r = 0; r < NROWS; r++) begin
        e.addr = AW'(r);
        e.data = modelWord(s) ^ inv;
        wrQ.push_back(e);
        s = modelStep(s);
      end
      for (int r = 0; r < NROWS; r++) rdQ.push_back(AW'(r));
    end
  endtask

  // Every cycle with WE or RE high must match the next scoreboard entry
  always @(posedge clk) begin
    #1;
    if (monOn) begin
      wrExp_t e;
      if (o_we && o_re) checkOutput("weReExclusive", 64'(o_we & o_re), 64'h0);
      if (o_we) begin
        if (wrQ.size() == 0) checkOutput("unexpectedWrite", 64'(o_we), 64'h0);
        else begin
          e = wrQ.pop_front();
          checkOutput("waddr", 64'(o_waddr), 64'(e.addr));
          checkOutput("din", o_din, e.data);
        end
      end
      if (o_re) begin
        if (rdQ.size() == 0) checkOutput("unexpectedRead", 64'(o_re), 64'h0);
        else checkOutput("raddr", 64'(o_raddr), 64'(rdQ.pop_front()));
      end
    end
  end

  task automatic applyStimulus(input string tag, input logic [31:0] sd, input int fault,
                               input int midStart, input bit forceSat, input bit expPass,
                               input logic [15:0] expErr, input logic [AW-1:0] expFirst);
    int doneEdge;
    faultMode = fault;
    wrQ.delete();
    rdQ.delete();
    pushExpected(sd);
    @(negedge clk);
    seed  = sd;
    start = 1'b1;
    monOn = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    checkOutput({tag, ".busyAfterStart"}, 64'(o_busy), 64'h1);
    checkOutput({tag, ".doneCleared"}, 64'(o_done), 64'h0);
    doneEdge = -1;
    for (int cyc = 1; cyc <= DONE_EDGE + 20; cyc++) begin
      @(posedge clk);
      #1;
      start = (cyc == midStart);
      if (forceSat && cyc == 20) force dut.r_errCount = 16'hFFFE;
      if (forceSat && cyc == 21) begin
        release dut.r_errCount;
        checkOutput({tag, ".preloadFFFE"}, 64'(o_err_count), 64'hFFFE);
      end
      if (o_done) begin
        doneEdge = cyc;
        break;
      end
    end
    start = 1'b0;
    if (doneEdge < 0) checkOutput({tag, ".doneTimeout"}, 64'h0, 64'h1);
    else checkOutput({tag, ".doneEdge"}, 64'(doneEdge), 64'(DONE_EDGE));
    checkOutput({tag, ".busyAtDone"}, 64'(o_busy), 64'h0);
    checkOutput({tag, ".pass"}, 64'(o_pass), 64'(expPass));
    checkOutput({tag, ".errCount"}, 64'(o_err_count), 64'(expErr));
    checkOutput({tag, ".firstErrAddr"}, 64'(o_first_err_addr), 64'(expFirst));
    checkOutput({tag, ".writesLeft"}, 64'(wrQ.size()), 64'h0);
    checkOutput({tag, ".readsLeft"}, 64'(rdQ.size()), 64'h0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput({tag, ".doneHeld"}, 64'(o_done), 64'h1);
    checkOutput({tag, ".idleWeRe"}, 64'({o_we, o_re}), 64'h0);
    monOn = 1'b0;
  endtask

  typedef struct {
    string         tag;
    logic [31:0]   seed;
    int            fault;
    int            midStart;
    bit            expPass;
    logic [15:0]   expErr;
    logic [AW-1:0] expFirst;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{"ace1Clean",  32'h0000_ACE1, 0, 0,   1'b1, 16'd0,     6'd0};
    vecs[1] = '{"ace1Flip5",  32'h0000_ACE1, 1, 0,   1'b0, FLIP_ERRS, 6'd5};
    vecs[2] = '{"seedZero",   32'h0000_0000, 0, 0,   1'b1, 16'd0,     6'd0};
    vecs[3] = '{"seedOne",    32'h0000_0001, 0, 0,   1'b1, 16'd0,     6'd0};
    vecs[4] = '{"midReadStart", 32'h0000_BEEF, 0, 100, 1'b1, 16'd0,   6'd0};
    vecs[5] = '{"seedOnes",   32'hFFFF_FFFF, 0, 0,   1'b1, 16'd0,     6'd0};

    rst_n = 1'b0;
    start = 1'b0;
    seed  = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    checkOutput("rst.busy", 64'(o_busy), 64'h0);
    checkOutput("rst.done", 64'(o_done), 64'h0);
    checkOutput("rst.pass", 64'(o_pass), 64'h0);
    checkOutput("rst.errCount", 64'(o_err_count), 64'h0);
    checkOutput("rst.firstErrAddr", 64'(o_first_err_addr), 64'h0);
    checkOutput("rst.weRe", 64'({o_we, o_re}), 64'h0);
    checkOutput("rst.addrs", 64'({o_waddr, o_raddr}), 64'h0);
    checkOutput("rst.din", o_din, 64'h0);
    checkOutput("rst.se", 64'(o_se), 64'h0);

    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].tag, vecs[v].seed, vecs[v].fault, vecs[v].midStart, 1'b0,
                    vecs[v].expPass, vecs[v].expErr, vecs[v].expFirst);
    end

    // Saturation: counter preloaded to FFFE during the write pass, then three read mismatches
    applyStimulus("saturate", 32'h1234_5678, 2, 0, 1'b1, 1'b0, 16'hFFFF, 6'd0);

    // Reset in the middle of the write pass aborts without ever raising DONE
    faultMode = 0;
    @(negedge clk);
    seed  = 32'h0000_ACE1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("midWrite.weBeforeReset", 64'(o_we), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midWrite.weAtReset", 64'(o_we), 64'h0);
    checkOutput("midWrite.busyAtReset", 64'(o_busy), 64'h0);
    checkOutput("midWrite.doneAtReset", 64'(o_done), 64'h0);
    checkOutput("midWrite.dinAtReset", o_din, 64'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("midWrite.doneAfter", 64'(o_done), 64'h0);
    checkOutput("midWrite.busyAfter", 64'(o_busy), 64'h0);
    checkOutput("midWrite.weReAfter", 64'({o_we, o_re}), 64'h0);

    applyStimulus("afterAbort", 32'h0000_ACE1, 0, 0, 1'b0, 1'b1, 16'd0, 6'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
